// File: rtl/icache_lock_ctrl.sv
// Loop-driven I-cache line locking: tracks lock bits per (set, way) during a loop episode.
// Optional statistics counters are built when ICACHE_LOCK_STATS_EN is defined.
module icache_lock_ctrl #(
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int MAX_LOCKED = 64,
  localparam int SIDX      = $clog2(SETS),
  localparam int WIDX      = $clog2(WAYS),
  localparam int CW        = $clog2(MAX_LOCKED) + 1
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            lock_start,
  input  logic            lock_cache,
  input  logic            hit_valid,
  input  logic [SIDX-1:0] hit_set,
  input  logic [WIDX-1:0] hit_way,
  input  logic            fill_valid,
  input  logic [SIDX-1:0] fill_set,
  input  logic [WIDX-1:0] fill_way,
  input  logic [SIDX-1:0] vic_set,
  output logic [WAYS-1:0] vic_lock_ways,
  output logic            lock_active,
  output logic [CW-1:0]   locked_cnt,
  output logic            budget_full,
  output logic [15:0]     episodes,
  output logic [15:0]     lock_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCK    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [WIDX:0] SET_CAP = (WIDX+1)'(WAYS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCKED);
  localparam logic [CW-1:0] CNT_MAX_M1 = CW'(MAX_LOCKED - 1);

  state_t                    state;
  logic [SETS-1:0][WAYS-1:0] lock_bits;

  function automatic logic [WIDX:0] pop_ways(input logic [WAYS-1:0] v);
    logic [WIDX:0] n;
    n = '0;
    for (int i = 0; i < WAYS; i++) n = n + (WIDX+1)'(v[i]);
    return n;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [WAYS-1:0] hit_row, fill_row;
  logic [WIDX:0]   hit_pop, fill_pop;
  logic            in_lock, same_set, same_line, fill_same;
  logic            fill_ok, hit_free, hit_room, hit_budget, hit_ok;
  logic [CW-1:0]   cnt_next;

  // Reads see the array as registered; this cycle's new locks land next cycle.
  assign vic_lock_ways = lock_bits[vic_set];
  assign hit_row       = lock_bits[hit_set];
  assign fill_row      = lock_bits[fill_set];
  assign hit_pop       = pop_ways(hit_row);
  assign fill_pop      = pop_ways(fill_row);

  assign in_lock   = (state == ST_LOCK);
  assign same_set  = (hit_set == fill_set);
  assign same_line = same_set && (hit_way == fill_way);

  // Fill takes priority; the hit is judged against what the fill consumes.
  assign fill_ok    = in_lock && fill_valid && !fill_row[fill_way] &&
                      (fill_pop < SET_CAP) && (locked_cnt < CNT_MAX);
  assign fill_same  = fill_ok && same_set;
  assign hit_free   = in_lock && hit_valid && !hit_row[hit_way] &&
                      !(fill_valid && same_line);
  assign hit_room   = (hit_pop + (WIDX+1)'(fill_same)) < SET_CAP;
  assign hit_budget = fill_ok ? (locked_cnt < CNT_MAX_M1) : (locked_cnt < CNT_MAX);
  assign hit_ok     = hit_free && hit_room && hit_budget;
  assign cnt_next   = locked_cnt + CW'(fill_ok) + CW'(hit_ok);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= ST_IDLE;
      lock_active <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state       <= lock_start ? ST_LOCK : ST_IDLE;
          lock_active <= lock_start;
        end
        ST_LOCK: begin
          if (lock_cache || lock_start) begin
            state       <= ST_LOCK;
            lock_active <= 1'b1;
          end else begin
            state       <= ST_RELEASE;
            lock_active <= 1'b0;
          end
        end
        ST_RELEASE: begin
          state       <= lock_start ? ST_LOCK : ST_IDLE;
          lock_active <= lock_start;
        end
        default: begin
          state       <= ST_IDLE;
          lock_active <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lock_bits <= '0;
    end else if (state == ST_RELEASE) begin
      lock_bits <= '0;
    end else begin
      if (fill_ok) lock_bits[fill_set][fill_way] <= 1'b1;
      if (hit_ok)  lock_bits[hit_set][hit_way]   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      locked_cnt  <= '0;
      budget_full <= 1'b0;
    end else if (state == ST_RELEASE) begin
      locked_cnt  <= '0;
      budget_full <= 1'b0;
    end else begin
      locked_cnt  <= cnt_next;
      budget_full <= (cnt_next == CNT_MAX);
    end
  end

`ifdef ICACHE_LOCK_STATS_EN
  logic enter_lock;
  assign enter_lock = lock_start && (state != ST_LOCK);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      episodes    <= '0;
      lock_cycles <= '0;
    end else begin
      if (enter_lock) episodes    <= sat_inc16(episodes);
      if (in_lock)    lock_cycles <= sat_inc16(lock_cycles);
    end
  end
`else
  assign episodes    = 16'd0;
  assign lock_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_icache_lock_ctrl.sv
// Scoreboard bench for icache_lock_ctrl: a sequential reference model predicts each cycle's outcome.
module tb_icache_lock_ctrl;
  localparam int SETS = 16;
  localparam int WAYS = 4;
  localparam int MAXL = 6;
  localparam int SIDX = 4;
  localparam int WIDX = 2;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_l;
  logic            lock_start, lock_cache;
  logic            hit_valid, fill_valid;
  logic [SIDX-1:0] hit_set, fill_set, vic_set;
  logic [WIDX-1:0] hit_way, fill_way;
  logic [WAYS-1:0] vic_lock_ways;
  logic            lock_active, budget_full;
  logic [CW-1:0]   locked_cnt;
  logic [15:0]     episodes, lock_cycles;

  always #5 clk = ~clk;

  icache_lock_ctrl #(.SETS(SETS), .WAYS(WAYS), .MAX_LOCKED(MAXL)) u_dut (
    .clk(clk), .rst_l(rst_l), .lock_start(lock_start), .lock_cache(lock_cache),
    .hit_valid(hit_valid), .hit_set(hit_set), .hit_way(hit_way),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
    .vic_set(vic_set), .vic_lock_ways(vic_lock_ways), .lock_active(lock_active),
    .locked_cnt(locked_cnt), .budget_full(budget_full),
    .episodes(episodes), .lock_cycles(lock_cycles)
  );

  typedef struct {
    logic            la;
    logic [CW-1:0]   cnt;
    logic            bf;
    logic [15:0]     ep;
    logic [15:0]     lc;
    logic [WAYS-1:0] vic;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: 0 idle, 1 lock, 2 release
  int              m_state;
  logic [WAYS-1:0] m_lock [SETS];
  int              m_cnt, m_ep, m_lc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt = 0;
    m_ep = 0;
    m_lc = 0;
    for (int s = 0; s < SETS; s++) m_lock[s] = '0;
  endtask

  task automatic try_lock(input int s, input int w);
    if (!m_lock[s][w] && $countones(m_lock[s]) < WAYS - 1 && m_cnt < MAXL) begin
      m_lock[s][w] = 1'b1;
      m_cnt++;
    end
  endtask

  task automatic cyc(input logic ls, input logic lc, input logic hv, input int hs, input int hw,
                     input logic fv, input int fs, input int fw, input int probe);
    exp_t e, g;
    int   nxt;
    @(negedge clk);
    lock_start = ls;
    lock_cache = lc;
    hit_valid  = hv;
    hit_set    = hs[SIDX-1:0];
    hit_way    = hw[WIDX-1:0];
    fill_valid = fv;
    fill_set   = fs[SIDX-1:0];
    fill_way   = fw[WIDX-1:0];
    vic_set    = probe[SIDX-1:0];
    #1;
    chk("vic_pre", 32'(vic_lock_ways), 32'(m_lock[probe]));
    case (m_state)
      0: nxt = ls ? 1 : 0;
      1: nxt = (lc || ls) ? 1 : 2;
      default: nxt = ls ? 1 : 0;
    endcase
    if (m_state == 1) begin
      if (fv) try_lock(fs, fw);
      if (hv) try_lock(hs, hw);
      if (m_lc < 16'hFFFF) m_lc++;
    end else if (m_state == 2) begin
      for (int s = 0; s < SETS; s++) m_lock[s] = '0;
      m_cnt = 0;
    end
    if (nxt == 1 && m_state != 1 && m_ep < 16'hFFFF) m_ep++;
    m_state = nxt;
    e.la  = (m_state == 1);
    e.cnt = CW'(m_cnt);
    e.bf  = (m_cnt == MAXL);
`ifdef ICACHE_LOCK_STATS_EN
    e.ep  = 16'(m_ep);
    e.lc  = 16'(m_lc);
`else
    e.ep  = 16'd0;
    e.lc  = 16'd0;
`endif
    e.vic = m_lock[probe];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb_q.pop_front();
      chk("lock_active", 32'(lock_active), 32'(g.la));
      chk("locked_cnt", 32'(locked_cnt), 32'(g.cnt));
      chk("budget_full", 32'(budget_full), 32'(g.bf));
      chk("vic_post", 32'(vic_lock_ways), 32'(g.vic));
      chk("episodes", 32'(episodes), 32'(g.ep));
      chk("lock_cycles", 32'(lock_cycles), 32'(g.lc));
    end
  endtask

  initial begin
    rst_l = 1'b0;
    lock_start = 0; lock_cache = 0; hit_valid = 0; fill_valid = 0;
    hit_set = '0; hit_way = '0; fill_set = '0; fill_way = '0; vic_set = 4'd5;
    model_reset();
    #12;
    chk("rst_lock_active", 32'(lock_active), 32'd0);
    chk("rst_locked_cnt", 32'(locked_cnt), 32'd0);
    chk("rst_budget_full", 32'(budget_full), 32'd0);
    chk("rst_vic", 32'(vic_lock_ways), 32'd0);
    chk("rst_episodes", 32'(episodes), 32'd0);
    chk("rst_lock_cycles", 32'(lock_cycles), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;

    cyc(0, 1, 1, 5, 2, 0, 0, 0, 5);           // idle: no locking, no state change
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 5);           // enter LOCK
    cyc(0, 1, 1, 5, 2, 0, 0, 0, 5);           // (5,2) -> 0100
    for (int w = 0; w < 4; w++) cyc(0, 1, 1, 3, w, 0, 0, 0, 3);
    cyc(0, 1, 1, 10, 1, 1, 10, 1, 10);        // same line counts once
    cyc(0, 1, 1, 7, 0, 1, 9, 1, 9);           // budget remainder 1: fill wins
    cyc(0, 1, 1, 11, 0, 0, 0, 0, 7);          // budget full: refused
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 3);           // -> RELEASE
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 3);           // -> IDLE, cleared
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 8);
    cyc(0, 1, 1, 8, 0, 1, 8, 1, 8);
    cyc(0, 1, 1, 8, 2, 1, 8, 3, 8);           // same-set room for one: fill wins
    cyc(1, 0, 0, 0, 0, 1, 8, 3, 8);           // nested start, fill to locked line
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 8);           // -> RELEASE
    cyc(1, 0, 1, 8, 0, 0, 0, 0, 8);           // RELEASE -> LOCK, cleared

    for (int i = 0; i < 60; i++) begin
      int hs, fs;
      hs = $urandom_range(0, 3);
      fs = $urandom_range(0, 3);
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) != 0),
          $urandom_range(0, 1), hs, $urandom_range(0, 3),
          $urandom_range(0, 1), fs, $urandom_range(0, 3), hs);
    end

    cyc(1, 1, 1, 2, 0, 0, 0, 0, 2);
    cyc(0, 1, 1, 2, 1, 1, 2, 0, 2);
    @(negedge clk);
    rst_l = 1'b0;
    vic_set = 4'd2;
    #1;
    chk("arst_lock_active", 32'(lock_active), 32'd0);
    chk("arst_locked_cnt", 32'(locked_cnt), 32'd0);
    chk("arst_budget_full", 32'(budget_full), 32'd0);
    chk("arst_vic", 32'(vic_lock_ways), 32'd0);
    chk("arst_episodes", 32'(episodes), 32'd0);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    cyc(0, 1, 1, 2, 0, 1, 2, 1, 2);           // needs lock_start to leave IDLE
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 2);
    cyc(0, 1, 1, 2, 3, 0, 0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_lock_ctrl.md
ICACHE_LOCK_CTRL -- requirements
Module: icache_lock_ctrl

Interface
REQ-001 SHALL have parameter SETS, 64, I-cache sets (power of 2); SIDX = log2(SETS).
REQ-002 SHALL have parameter WAYS, 4, I-cache ways (power of 2, >= 2); WIDX = log2(WAYS).
REQ-003 SHALL have parameter MAX_LOCKED, 64, global limit on simultaneously locked lines.
REQ-004 SHALL have port clk, input, 1, single clock; all flops on rising edge.
REQ-005 SHALL have port rst_l, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port lock_start, input, 1, loop detector push (new backward loop).
REQ-007 SHALL have port lock_cache, input, 1, loop detector "keep locked" level.
REQ-008 SHALL have ports hit_valid, hit_set, hit_way, input, 1/SIDX/WIDX, fetch hit on (set, way).
REQ-009 SHALL have ports fill_valid, fill_set, fill_way, input, 1/SIDX/WIDX, line fill into (set, way).
REQ-010 SHALL have port vic_set, input, SIDX, set currently selecting a replacement victim.
REQ-011 SHALL have port vic_lock_ways, output, WAYS, combinational lock bits of vic_set.
REQ-012 SHALL have port lock_active, output, 1, registered; high in state LOCK.
REQ-013 SHALL have port locked_cnt, output, log2(MAX_LOCKED)+1, registered count of set lock bits.
REQ-014 SHALL have port budget_full, output, 1, registered; locked_cnt == MAX_LOCKED.
REQ-015 SHALL have ports episodes, lock_cycles, output, 16 each, statistics (see Configuration).

Function
REQ-016 SHALL hold a SETS x WAYS lock-bit array plus a 2-bit FSM: IDLE, LOCK, RELEASE.
REQ-017 IDLE -> LOCK when lock_start=1; otherwise stay IDLE; no lock bits set in IDLE.
REQ-018 LOCK: stay while lock_cache=1; -> RELEASE on the first cycle lock_cache=0 (lock_start=1 also holds LOCK).
REQ-019 RELEASE: clear all lock bits and locked_cnt in that single cycle; next state LOCK if lock_start=1, else IDLE.
REQ-020 In LOCK, a valid hit or fill SHALL set bit (set, way) next cycle if not already set and the candidate passes REQ-021/REQ-022.
REQ-021 Per-set rule: a lock SHALL never leave a set with zero unlocked ways (at most WAYS-1 locked per set).
REQ-022 Budget rule: new locks SHALL be refused when locked_cnt would exceed MAX_LOCKED.
REQ-023 Hit and fill to the same (set, way) in one cycle SHALL count as one lock.
REQ-024 Hit and fill that both qualify but only one fits (same-set rule or budget remainder 1): fill wins, hit dropped.
REQ-025 locked_cnt SHALL increment by the number of newly set bits (0, 1 or 2) per cycle, never wrap.
REQ-026 Fill to an already-locked (set, way) SHALL not occur; if it does, bit stays set and count unchanged.
REQ-027 vic_lock_ways SHALL reflect the array state before the current cycle's updates (no bypass).
REQ-028 lock_start without preceding lock_cache deassert SHALL not clear existing locks (nested loops keep outer lines).

Reset
REQ-029 On rst_l=0: FSM=IDLE, lock array all 0, locked_cnt=0, lock_active=0, budget_full=0, episodes=0, lock_cycles=0.
REQ-030 Reset asserted mid-LOCK SHALL discard all locks immediately (asynchronously); no RELEASE cycle.
REQ-031 First state change after rst_l rises requires lock_start sampled high on a clk edge.

Configuration
REQ-032 Macro ICACHE_LOCK_STATS_EN defined: episodes increments (saturating at 0xFFFF) on each IDLE->LOCK or RELEASE->LOCK; lock_cycles increments (saturating) every cycle in LOCK.
REQ-033 Macro ICACHE_LOCK_STATS_EN undefined: episodes and lock_cycles tied to 0, no counter flops instantiated; all other behaviour identical.

Verification
REQ-034 Reset, lock_start=1 one cycle, then hit set 5 way 2 -> lock_active=1 next cycle, vic_set=5 gives vic_lock_ways=4'b0100, locked_cnt=1.
REQ-035 In LOCK, hits to set 3 ways 0,1,2,3 on four cycles -> ways 0-2 locked, way 3 refused, vic_lock_ways=4'b0111, locked_cnt=3.
REQ-036 MAX_LOCKED=2, locked_cnt=1, same-cycle hit (7,0) and fill (9,1) -> only (9,1) locked, locked_cnt=2, budget_full=1.
REQ-037 In LOCK with 3 locks, lock_cache=0 one cycle -> RELEASE next cycle, then IDLE, locked_cnt=0, all vic_lock_ways=0.
REQ-038 Hit and fill both to (10,1) in LOCK -> locked_cnt increments by exactly 1.
REQ-039 ICACHE_LOCK_STATS_EN defined, two lock episodes of 5 and 3 cycles -> episodes=2, lock_cycles=8; undefined -> both read 0.
